// File: rtl/exec_pkg.sv
// exec_pkg: shared definitions for the execute-stage ALU arbiter.
//   - ALU ifun codes (add/sub/and/xor); every other code is illegal.
//   - jXX/cmovXX condition codes and the condition evaluation helper.
//   - Bit positions of the flags inside the condition-code register.
//   - FSM state encoding of the arbiter.
package exec_pkg;

  localparam logic [3:0] ALU_ADD = 4'd0;
  localparam logic [3:0] ALU_SUB = 4'd1;
  localparam logic [3:0] ALU_AND = 4'd2;
  localparam logic [3:0] ALU_XOR = 4'd3;

  localparam logic [3:0] COND_ALWAYS = 4'd0;
  localparam logic [3:0] COND_LE     = 4'd1;
  localparam logic [3:0] COND_L      = 4'd2;
  localparam logic [3:0] COND_E      = 4'd3;
  localparam logic [3:0] COND_NE     = 4'd4;
  localparam logic [3:0] COND_GE     = 4'd5;
  localparam logic [3:0] COND_G      = 4'd6;

  // Flag positions inside cc = {OF,SF,ZF}
  localparam int CC_ZF = 0;
  localparam int CC_SF = 1;
  localparam int CC_OF = 2;

  localparam logic [2:0] CC_RESET = 3'b001;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_e;

  // Evaluate a jXX/cmovXX condition against a condition-code value.
  function automatic logic cond_eval(input logic [3:0] fun, input logic [2:0] cc);
    logic lt;
    logic res;
    lt = cc[CC_SF] ^ cc[CC_OF];
    case (fun)
      COND_ALWAYS: res = 1'b1;
      COND_LE:     res = lt | cc[CC_ZF];
      COND_L:      res = lt;
      COND_E:      res = cc[CC_ZF];
      COND_NE:     res = ~cc[CC_ZF];
      COND_GE:     res = ~lt;
      COND_G:      res = ~lt & ~cc[CC_ZF];
      default:     res = 1'b0;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/alu_cc_64bit.sv
// alu_cc_64bit: combinational execute ALU with condition-flag generation.
// Ports:
//   fun     in   4      ALU ifun (add/sub/and/xor)
//   a, b    in   WIDTH  operands valA / valB; result is b OP a
//   result  out  WIDTH  valE, zero for an illegal ifun
//   flags   out  3      {OF,SF,ZF} of the result
//   illegal out  1      ifun is not one of the four ALU operations
module alu_cc_64bit
  import exec_pkg::*;
#(
  parameter int WIDTH = 64
) (
  input  logic [3:0]       fun,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] result,
  output logic [2:0]       flags,
  output logic             illegal
);

  logic of;

  always_comb begin
    result  = '0;
    of      = 1'b0;
    illegal = 1'b0;
    case (fun)
      ALU_ADD: begin
        result = b + a;
        // Same-signed operands producing a differently-signed sum
        of = (a[WIDTH-1] == b[WIDTH-1]) && (result[WIDTH-1] != a[WIDTH-1]);
      end
      ALU_SUB: begin
        result = b - a;
        // b - a overflows when the operands differ in sign and the result
        // takes the sign of a
        of = (a[WIDTH-1] != b[WIDTH-1]) && (result[WIDTH-1] != b[WIDTH-1]);
      end
      ALU_AND: result = b & a;
      ALU_XOR: result = b ^ a;
      default: illegal = 1'b1;
    endcase
  end

  always_comb begin
    flags        = '0;
    flags[CC_ZF] = (result == '0);
    flags[CC_SF] = result[WIDTH-1];
    flags[CC_OF] = of;
  end

endmodule

// File: rtl/alu_arbiter_cc.sv
// alu_arbiter_cc: one execute ALU shared round-robin between two requesters,
// holding the architectural condition-code register and evaluating jXX/cmovXX
// conditions from it.
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   req_valid    in  2        per-requester request valid
//   req_ready    out 2        per-requester grant, one-hot or zero
//   req_fun      in  8        ifun per requester ([3:0]=req0, [7:4]=req1)
//   req_a/req_b  in  2*WIDTH  operands per requester (low half = req0)
//   req_set_cc   in  2        op updates CC
//   rsp_valid    out 1        result valid (held until rsp_ready)
//   rsp_ready    in  1        consumer accepts result
//   rsp_id       out 1        requester index of the result
//   rsp_result   out WIDTH    valE
//   rsp_err      out 1        illegal ifun
//   cc_q         out 3        {OF,SF,ZF}
//   cond_fun     in  4        condition to evaluate
//   cond_true    out 1        condition from current cc_q
//
// Handshake: a request transfers on a rising edge where req_valid[i] and
// req_ready[i] are both high; a response transfers on a rising edge where
// rsp_valid and rsp_ready are both high. req_ready is only ever raised in IDLE,
// and rsp_valid with all rsp_* outputs stays stable until that transfer.
module alu_arbiter_cc
  import exec_pkg::*;
#(
  parameter int WIDTH = 64
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [1:0]           req_valid,
  output logic [1:0]           req_ready,
  input  logic [7:0]           req_fun,
  input  logic [2*WIDTH-1:0]   req_a,
  input  logic [2*WIDTH-1:0]   req_b,
  input  logic [1:0]           req_set_cc,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic                 rsp_id,
  output logic [WIDTH-1:0]     rsp_result,
  output logic                 rsp_err,
  output logic [2:0]           cc_q,
  input  logic [3:0]           cond_fun,
  output logic                 cond_true
);

  state_e            state_q;
  logic              last_grant_q;
  logic [3:0]        fun_q;
  logic [WIDTH-1:0]  a_q;
  logic [WIDTH-1:0]  b_q;
  logic              set_cc_q;
  logic              id_q;

  logic              win_id;
  logic [WIDTH-1:0]  alu_result;
  logic [2:0]        alu_flags;
  logic              alu_illegal;

  // Requester 1 wins when it is the only one asking, or when both ask and
  // requester 0 had the previous grant.
  always_comb begin
    win_id    = req_valid[1] & (~req_valid[0] | ~last_grant_q);
    req_ready = 2'b00;
    if (state_q == IDLE && req_valid != 2'b00) begin
      req_ready = win_id ? 2'b10 : 2'b01;
    end
  end

  alu_cc_64bit #(.WIDTH(WIDTH)) u_alu (
    .fun     (fun_q),
    .a       (a_q),
    .b       (b_q),
    .result  (alu_result),
    .flags   (alu_flags),
    .illegal (alu_illegal)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      fun_q        <= '0;
      a_q          <= '0;
      b_q          <= '0;
      set_cc_q     <= 1'b0;
      id_q         <= 1'b0;
      rsp_id       <= 1'b0;
      rsp_result   <= '0;
      rsp_err      <= 1'b0;
      cc_q         <= CC_RESET;
    end else begin
      case (state_q)
        IDLE: begin
          if (req_ready != 2'b00) begin
            fun_q        <= win_id ? req_fun[7:4] : req_fun[3:0];
            a_q          <= win_id ? req_a[2*WIDTH-1:WIDTH] : req_a[WIDTH-1:0];
            b_q          <= win_id ? req_b[2*WIDTH-1:WIDTH] : req_b[WIDTH-1:0];
            set_cc_q     <= req_set_cc[win_id];
            id_q         <= win_id;
            last_grant_q <= win_id;
            state_q      <= EXEC;
          end
        end
        EXEC: begin
          rsp_result <= alu_result;
          rsp_err    <= alu_illegal;
          rsp_id     <= id_q;
          if (set_cc_q && !alu_illegal) begin
            cc_q <= alu_flags;
          end
          state_q <= RESP;
        end
        RESP: begin
          if (rsp_ready) begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Decoded from the state register, so it drops as soon as rst_n falls.
  assign rsp_valid = (state_q == RESP);
  assign cond_true = cond_eval(cond_fun, cc_q);

endmodule

// File: tb/tb_alu_arbiter_cc.sv
module tb_alu_arbiter_cc;

  localparam int W = 64;

  logic            clk;
  logic            rst_n;
  logic [1:0]      req_valid;
  logic [1:0]      req_ready;
  logic [7:0]      req_fun;
  logic [2*W-1:0]  req_a;
  logic [2*W-1:0]  req_b;
  logic [1:0]      req_set_cc;
  logic            rsp_valid;
  logic            rsp_ready;
  logic            rsp_id;
  logic [W-1:0]    rsp_result;
  logic            rsp_err;
  logic [2:0]      cc_q;
  logic [3:0]      cond_fun;
  logic            cond_true;

  alu_arbiter_cc #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_fun    (req_fun),
    .req_a      (req_a),
    .req_b      (req_b),
    .req_set_cc (req_set_cc),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_id     (rsp_id),
    .rsp_result (rsp_result),
    .rsp_err    (rsp_err),
    .cc_q       (cc_q),
    .cond_fun   (cond_fun),
    .cond_true  (cond_true)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  int n_cmp = 0;
  int n_err = 0;
  logic [W-1:0] exp_q[$];
  logic [2:0]   mdl_cc;     // {OF,SF,ZF}
  int           mdl_last;   // requester granted most recently

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference ALU: arithmetic done with one extra sign bit, overflow is the
  // true signed result not fitting in W bits.
  task automatic mdl_exec(input logic [3:0] fun, input logic [W-1:0] a, input logic [W-1:0] b,
                          output logic [W-1:0] r, output logic [2:0] f, output logic err);
    logic [W:0] wide;
    logic of;
    err = 1'b0;
    of  = 1'b0;
    wide = '0;
    case (fun)
      4'd0: begin wide = {b[W-1], b} + {a[W-1], a}; r = wide[W-1:0]; of = wide[W] != wide[W-1]; end
      4'd1: begin wide = {b[W-1], b} - {a[W-1], a}; r = wide[W-1:0]; of = wide[W] != wide[W-1]; end
      4'd2: r = b & a;
      4'd3: r = b ^ a;
      default: begin r = '0; err = 1'b1; end
    endcase
    f = {of, r[W-1], r == '0};
  endtask

  function automatic logic mdl_cond(input logic [3:0] fun, input logic [2:0] cc);
    logic zf, sf, of_;
    zf = cc[0]; sf = cc[1]; of_ = cc[2];
    case (fun)
      4'd0: return 1'b1;
      4'd1: return (sf != of_) || zf;
      4'd2: return sf != of_;
      4'd3: return zf;
      4'd4: return !zf;
      4'd5: return sf == of_;
      4'd6: return (sf == of_) && !zf;
      default: return 1'b0;
    endcase
  endfunction

  // ---------------- driver tasks ----------------
  task automatic drive_req(input int id, input logic [3:0] fun, input logic [W-1:0] a,
                           input logic [W-1:0] b, input logic sc);
    if (id == 0) begin
      req_fun[3:0] = fun; req_a[W-1:0] = a; req_b[W-1:0] = b; req_set_cc[0] = sc;
    end else begin
      req_fun[7:4] = fun; req_a[2*W-1:W] = a; req_b[2*W-1:W] = b; req_set_cc[1] = sc;
    end
    req_valid[id] = 1'b1;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst_n = 1'b0;
    req_valid = 2'b00;
    rsp_ready = 1'b0;
    #1;
    mdl_cc = 3'b001;
    mdl_last = 1;
    exp_q.delete();
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_cc", cc_q, 3'b001);
    check("rst_req_ready", req_ready, 0);
    check("rst_rsp_result", rsp_result, 0);
    check("rst_rsp_err", rsp_err, 0);
    check("rst_rsp_id", rsp_id, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Called at the negedge in EXEC after a grant to requester id. Checks the EXEC
  // cycle, the response, an optional back-pressure hold, then completes the handshake.
  task automatic finish_op(input int id, input logic [3:0] fun, input logic [W-1:0] a,
                           input logic [W-1:0] b, input logic sc, input int hold);
    logic [W-1:0] r, exp_r;
    logic [2:0] f, cc_old;
    logic err;
    logic [3:0] cf;
    mdl_exec(fun, a, b, r, f, err);
    exp_q.push_back(r);
    cc_old = mdl_cc;
    // EXEC: no response yet, flags still the old ones
    cf = 4'($urandom_range(0, 15));
    cond_fun = cf;
    #1;
    check("exec_rsp_valid", rsp_valid, 0);
    check("exec_req_ready", req_ready, 0);
    check("exec_cc_old", cc_q, cc_old);
    check("exec_cond_old", cond_true, mdl_cond(cf, cc_old));
    @(negedge clk);
    if (sc && !err) mdl_cc = f;
    exp_r = exp_q.pop_front();
    check("rsp_valid", rsp_valid, 1);
    check("rsp_result", rsp_result, exp_r);
    check("rsp_err", rsp_err, err);
    check("rsp_id", rsp_id, id);
    check("rsp_cc", cc_q, mdl_cc);
    for (int c = 0; c < 16; c++) begin
      cond_fun = 4'(c);
      #1;
      check($sformatf("cond_%0d", c), cond_true, mdl_cond(4'(c), mdl_cc));
    end
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      // other requester asks during RESP and may drop again before any grant
      req_valid[1 - id] = (h == 0);
      #1;
      check("hold_rsp_valid", rsp_valid, 1);
      check("hold_req_ready", req_ready, 0);
      check("hold_rsp_result", rsp_result, exp_r);
      check("hold_rsp_id", rsp_id, id);
      check("hold_cc", cc_q, mdl_cc);
    end
    if (hold > 0) req_valid[1 - id] = 1'b0;
    rsp_ready = 1'b1;
    @(posedge clk);
    #1 rsp_ready = 1'b0;
  endtask

  // Waits (bounded) for requester id to be granted; returns 1 on grant, with the
  // handshake edge consumed and time placed at the following negedge.
  task automatic wait_grant(input int id, input logic [1:0] exp_ready, output bit ok);
    int waited = 0;
    #1;
    while (req_ready[id] !== 1'b1 && waited < 10) begin
      @(negedge clk);
      #1;
      waited++;
    end
    ok = (req_ready[id] === 1'b1);
    if (!ok) begin
      check("grant_timeout", 0, 1);
      return;
    end
    check("req_ready", req_ready, exp_ready);
    @(posedge clk);
    mdl_last = id;
    @(negedge clk);
  endtask

  task automatic do_op(input int id, input logic [3:0] fun, input logic [W-1:0] a,
                       input logic [W-1:0] b, input logic sc, input int hold);
    bit ok;
    @(negedge clk);
    drive_req(id, fun, a, b, sc);
    wait_grant(id, (id == 0) ? 2'b01 : 2'b10, ok);
    req_valid[id] = 1'b0;
    if (ok) finish_op(id, fun, a, b, sc, hold);
    else req_valid = 2'b00;
  endtask

  function automatic logic [W-1:0] rand_operand();
    case ($urandom_range(0, 5))
      0: return 64'h7FFF_FFFF_FFFF_FFFF;
      1: return 64'h8000_0000_0000_0000;
      2: return '0;
      3: return '1;
      default: return {$urandom(), $urandom()};
    endcase
  endfunction

  // ---------------- stimulus ----------------
  initial begin
    bit ok;
    rst_n = 1'b0;
    req_valid = 2'b00;
    req_fun = '0;
    req_a = '0;
    req_b = '0;
    req_set_cc = '0;
    rsp_ready = 1'b0;
    cond_fun = '0;
    mdl_cc = 3'b001;
    mdl_last = 1;

    apply_reset();

    // Directed cases
    do_op(0, 4'd0, 64'd5, 64'd7, 1'b1, 0);
    do_op(1, 4'd1, 64'd7, 64'd7, 1'b1, 0);
    do_op(0, 4'd0, 64'h7FFF_FFFF_FFFF_FFFF, 64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 0);
    check("add_ovf_cc", cc_q, 3'b110);
    do_op(0, 4'd4, 64'd1, 64'd2, 1'b1, 0);
    do_op(1, 4'd3, 64'd3, 64'd3, 1'b0, 0);
    check("no_setcc_cc", cc_q, 3'b110);

    // Reset while an op is in EXEC: response never appears, CC returns to reset
    @(negedge clk);
    drive_req(0, 4'd0, 64'd1, 64'd1, 1'b1);
    wait_grant(0, 2'b01, ok);
    req_valid = 2'b00;
    rst_n = 1'b0;
    #1;
    check("abort_rsp_valid", rsp_valid, 0);
    check("abort_cc", cc_q, 3'b001);
    mdl_cc = 3'b001;
    mdl_last = 1;
    @(negedge clk);
    rst_n = 1'b1;
    do_op(1, 4'd2, 64'hF0F0, 64'hFF00, 1'b1, 0);

    // Both requesters valid continuously: grants alternate starting with req0
    apply_reset();
    @(negedge clk);
    drive_req(0, 4'd0, 64'd10, 64'd20, 1'b1);
    drive_req(1, 4'd1, 64'd30, 64'd20, 1'b1);
    for (int k = 0; k < 4; k++) begin
      int w;
      w = 1 - mdl_last;
      check("rr_expected_order", w, k % 2);
      wait_grant(w, (w == 0) ? 2'b01 : 2'b10, ok);
      if (!ok) break;
      if (w == 0) finish_op(0, 4'd0, 64'd10, 64'd20, 1'b1, (k == 0) ? 5 : 0);
      else        finish_op(1, 4'd1, 64'd30, 64'd20, 1'b1, 0);
      req_valid = 2'b11;
      @(negedge clk);
    end
    req_valid = 2'b00;

    // Randomized ops
    for (int n = 0; n < 40; n++) begin
      do_op($urandom_range(0, 1), 4'($urandom_range(0, 5)), rand_operand(), rand_operand(),
            1'($urandom_range(0, 1)), $urandom_range(0, 2));
    end

    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  // Global time limit so the bench always ends
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, got %0d expected 0", n_cmp);
    n_err++;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
